// File: rtl/nic_fifo.sv
// rtl/nic_fifo.sv - NIC with DEPTH-entry RX/TX FIFOs between a processor port and a mesh router port
// Optional sticky underflow/overflow status flags: define NIC_FIFO_ERR_STATUS_EN
module nic_fifo #(
    parameter int PACKET_SIZE = 64,
    parameter int DEPTH       = 4,
    parameter int CNT_W       = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             addr,
    input  logic [0:PACKET_SIZE-1] d_in,
    output logic [0:PACKET_SIZE-1] d_out,
    input  logic                   nicEn,
    input  logic                   nicEnWr,
    input  logic                   net_si,
    output logic                   net_ri,
    input  logic [0:PACKET_SIZE-1] net_di,
    output logic                   net_so,
    input  logic                   net_ro,
    output logic [0:PACKET_SIZE-1] net_do,
    input  logic                   net_polarity
);

    localparam int PTR_W = $clog2(DEPTH);

    // Storage is never reset; only pointers and counts define what is valid.
    logic [0:PACKET_SIZE-1] rx_mem_q [DEPTH];
    logic [0:PACKET_SIZE-1] tx_mem_q [DEPTH];

    logic [PTR_W-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [PTR_W-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;

    logic rx_full, rx_empty, tx_full, tx_empty;
    logic proc_rd, proc_wr;
    logic rx_push, rx_pop, tx_push, tx_pop;
    logic rx_err, tx_err;

    assign rx_full  = (rx_cnt_q == CNT_W'(DEPTH));
    assign rx_empty = (rx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == CNT_W'(DEPTH));
    assign tx_empty = (tx_cnt_q == '0);

    // Every strobe is qualified by reset so nothing moves while it is held.
    assign proc_rd = reset && nicEn && !nicEnWr;
    assign proc_wr = reset && nicEn && nicEnWr;

    assign rx_push = reset && net_si && !rx_full;
    assign rx_pop  = proc_rd && (addr == 2'b00) && !rx_empty;
    assign tx_push = proc_wr && (addr == 2'b10) && !tx_full;
    assign tx_pop  = net_so;

    // net_ri follows registered fullness only; a same-cycle pop does not open it.
    assign net_ri = !reset || !rx_full;
    assign net_do = tx_mem_q[tx_rd_q];
    // Head may leave only when its VC bit differs from the router polarity.
    assign net_so = reset && !tx_empty && net_ro && (net_do[0] != net_polarity);

    function automatic logic [0:PACKET_SIZE-1] status_word(
        input logic             full,
        input logic             empty,
        input logic             err,
        input logic [CNT_W-1:0] cnt
    );
        logic [0:PACKET_SIZE-1] s;
        s                  = '0;
        s[PACKET_SIZE-1]   = full;
        s[PACKET_SIZE-2]   = empty;
        s[PACKET_SIZE-3]   = err;
        s[0:CNT_W-1]       = cnt;
        return s;
    endfunction

    // Next-state for both FIFOs' pointers and counts.
    always_comb begin
        rx_wr_d  = rx_push ? rx_wr_q + PTR_W'(1) : rx_wr_q;
        rx_rd_d  = rx_pop  ? rx_rd_q + PTR_W'(1) : rx_rd_q;
        tx_wr_d  = tx_push ? tx_wr_q + PTR_W'(1) : tx_wr_q;
        tx_rd_d  = tx_pop  ? tx_rd_q + PTR_W'(1) : tx_rd_q;
        rx_cnt_d = rx_cnt_q;
        tx_cnt_d = tx_cnt_q;
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + CNT_W'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - CNT_W'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + CNT_W'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - CNT_W'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    // Pointer and count registers; reset drops every queued packet.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
            rx_cnt_q <= rx_cnt_d;
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            tx_cnt_q <= tx_cnt_d;
        end
    end

    // FIFO storage writes.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem_q[rx_wr_q] <= net_di;
        if (tx_push) tx_mem_q[tx_wr_q] <= d_in;
    end

`ifdef NIC_FIFO_ERR_STATUS_EN
    logic rx_uf_q, rx_uf_d, tx_of_q, tx_of_d;
    logic rx_uf_set, tx_of_set, rx_stat_rd, tx_stat_rd;

    assign rx_uf_set  = proc_rd && (addr == 2'b00) && rx_empty;
    assign tx_of_set  = proc_wr && (addr == 2'b10) && tx_full;
    assign rx_stat_rd = proc_rd && (addr == 2'b01);
    assign tx_stat_rd = proc_rd && (addr == 2'b11);

    // Read-to-clear sticky flags; a coincident set event wins over the clear.
    always_comb begin
        rx_uf_d = rx_uf_set || (rx_uf_q && !rx_stat_rd);
        tx_of_d = tx_of_set || (tx_of_q && !tx_stat_rd);
    end

    // Sticky flag registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_uf_q <= 1'b0;
            tx_of_q <= 1'b0;
        end else begin
            rx_uf_q <= rx_uf_d;
            tx_of_q <= tx_of_d;
        end
    end

    assign rx_err = rx_uf_q;
    assign tx_err = tx_of_q;
`else
    assign rx_err = 1'b0;
    assign tx_err = 1'b0;
`endif

    // Processor read mux; zero whenever there is no read or reset is held.
    always_comb begin
        d_out = '0;
        if (proc_rd) begin
            case (addr)
                2'b00:   if (!rx_empty) d_out = rx_mem_q[rx_rd_q];
                2'b01:   d_out = status_word(rx_full, rx_empty, rx_err, rx_cnt_q);
                2'b11:   d_out = status_word(tx_full, tx_empty, tx_err, tx_cnt_q);
                default: d_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_nic_fifo.sv
// tb/tb_nic_fifo.sv - scoreboard bench for nic_fifo
module tb_nic_fifo;

    localparam int P     = 64;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

`ifdef NIC_FIFO_ERR_STATUS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   addr;
    logic [0:P-1] d_in, d_out, net_di, net_do;
    logic         nicEn, nicEnWr, net_si, net_ri, net_so, net_ro, net_polarity;

    int checks   = 0;
    int failures = 0;

    logic [0:P-1] rx_q[$];
    logic [0:P-1] tx_q[$];
    logic         rx_err_m = 1'b0;
    logic         tx_err_m = 1'b0;

    nic_fifo #(.PACKET_SIZE(P), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
        .nicEn(nicEn), .nicEnWr(nicEnWr), .net_si(net_si), .net_ri(net_ri),
        .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
        .net_polarity(net_polarity)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [0:P-1] obs, input logic [0:P-1] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [0:P-1] stat(input logic full, input logic empty,
                                          input logic err, input logic [CNT_W-1:0] cnt);
        logic [0:P-1] s;
        s          = '0;
        s[P-1]     = full;
        s[P-2]     = empty;
        s[P-3]     = err;
        s[0:CNT_W-1] = cnt;
        return s;
    endfunction

    // One clock cycle: inputs are already set (after a negedge); check, clock, update model.
    task automatic cycle(input string tag);
        logic [0:P-1] exp_d;
        logic exp_so, rd, wr, rx_push, rx_pop, tx_push, rx_set, rx_clr, tx_set, tx_clr;
        int rxn, txn;
        #1;
        rxn = rx_q.size();
        txn = tx_q.size();
        rd  = nicEn && !nicEnWr;
        wr  = nicEn && nicEnWr;
        if (!reset) begin
            chk1({tag, ":ri"}, net_ri, 1'b1);
            chk1({tag, ":so"}, net_so, 1'b0);
            chk({tag, ":dout"}, d_out, '0);
            @(posedge clk);
            rx_q.delete();
            tx_q.delete();
            rx_err_m = 1'b0;
            tx_err_m = 1'b0;
        end else begin
            exp_d = '0;
            if (rd) begin
                case (addr)
                    2'd0:    if (rxn > 0) exp_d = rx_q[0];
                    2'd1:    exp_d = stat(rxn == DEPTH, rxn == 0, ERR_EN && rx_err_m, CNT_W'(rxn));
                    2'd3:    exp_d = stat(txn == DEPTH, txn == 0, ERR_EN && tx_err_m, CNT_W'(txn));
                    default: exp_d = '0;
                endcase
            end
            exp_so = 1'b0;
            if (txn > 0) exp_so = net_ro && (tx_q[0][0] != net_polarity);
            chk1({tag, ":ri"}, net_ri, rxn < DEPTH);
            chk1({tag, ":so"}, net_so, exp_so);
            chk({tag, ":dout"}, d_out, exp_d);
            if (txn > 0) chk({tag, ":do"}, net_do, tx_q[0]);
            rx_pop  = rd && addr == 2'd0 && rxn > 0;
            rx_push = net_si && rxn < DEPTH;
            tx_push = wr && addr == 2'd2 && txn < DEPTH;
            rx_set  = rd && addr == 2'd0 && rxn == 0;
            rx_clr  = rd && addr == 2'd1;
            tx_set  = wr && addr == 2'd2 && txn == DEPTH;
            tx_clr  = rd && addr == 2'd3;
            @(posedge clk);
            if (rx_pop)  void'(rx_q.pop_front());
            if (rx_push) rx_q.push_back(net_di);
            if (exp_so)  void'(tx_q.pop_front());
            if (tx_push) tx_q.push_back(d_in);
            rx_err_m = rx_set || (rx_err_m && !rx_clr);
            tx_err_m = tx_set || (tx_err_m && !tx_clr);
        end
        @(negedge clk);
    endtask

    task automatic proc_write(input logic [1:0] a, input logic [0:P-1] v, input string tag);
        nicEn = 1'b1; nicEnWr = 1'b1; addr = a; d_in = v;
        cycle(tag);
        nicEn = 1'b0; nicEnWr = 1'b0;
    endtask

    task automatic proc_read(input logic [1:0] a, input string tag);
        nicEn = 1'b1; nicEnWr = 1'b0; addr = a;
        cycle(tag);
        nicEn = 1'b0;
    endtask

    initial begin
        reset = 1'b0; addr = 2'd0; d_in = '0; nicEn = 1'b1; nicEnWr = 1'b0;
        net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
        @(negedge clk);
        cycle("rst0");
        cycle("rst1");
        reset = 1'b1; nicEn = 1'b0;
        cycle("idle");
        proc_read(2'd1, "rx_stat_reset");

        // RX fill; fifth offer arrives while full and must be refused
        for (int i = 1; i <= 5; i++) begin
            net_si = 1'b1;
            net_di = 64'(i * 'h11);
            cycle("rx_fill");
        end
        net_si = 1'b0;
        proc_read(2'd1, "rx_stat_full");
        for (int i = 0; i < 4; i++) proc_read(2'd0, "rx_pop");
        proc_read(2'd0, "rx_underflow");
        proc_read(2'd1, "rx_stat_err");
        proc_read(2'd1, "rx_stat_clr");

        // Writes to non-TX-data addresses are ignored
        proc_write(2'd0, 64'hDEAD_BEEF_0000_0001, "wr_ignored");
        proc_read(2'd3, "tx_stat_empty");

        // TX polarity gating
        net_ro = 1'b1; net_polarity = 1'b0;
        proc_write(2'd2, 64'h0000_0000_0000_0001, "tx_w_even");
        proc_write(2'd2, 64'h8000_0000_0000_0000, "tx_w_odd");
        cycle("tx_hold");
        net_polarity = 1'b1;
        cycle("tx_send_even");
        net_polarity = 1'b0;
        cycle("tx_send_odd");
        cycle("tx_drained");

        // TX overflow then back-to-back drain
        net_ro = 1'b0;
        for (int i = 0; i < 5; i++) proc_write(2'd2, 64'(i + 'h100), "tx_fill");
        proc_read(2'd3, "tx_stat_ovf");
        proc_read(2'd3, "tx_stat_clr");
        net_ro = 1'b1; net_polarity = 1'b1;
        for (int i = 0; i < 5; i++) cycle("tx_b2b");

        // Simultaneous RX push and pop at count 2 across pointer wrap
        net_si = 1'b1;
        net_di = 64'h00A0; cycle("rx_pre0");
        net_di = 64'h00A1; cycle("rx_pre1");
        for (int i = 0; i < 8; i++) begin
            net_di = 64'('hB0 + i);
            nicEn = 1'b1; nicEnWr = 1'b0; addr = 2'd0;
            cycle("rx_pushpop");
        end
        net_si = 1'b0; nicEn = 1'b0;
        proc_read(2'd1, "rx_stat_cnt2");
        proc_read(2'd0, "rx_tail0");
        proc_read(2'd0, "rx_tail1");

        // Mid-operation reset discards queued TX packets
        net_ro = 1'b0;
        proc_write(2'd2, 64'h10, "tx_pre_rst");
        proc_write(2'd2, 64'h20, "tx_pre_rst");
        proc_write(2'd2, 64'h30, "tx_pre_rst");
        proc_read(2'd3, "tx_stat_cnt3");
        reset = 1'b0;
        cycle("mid_rst");
        reset = 1'b1; net_ro = 1'b1; net_polarity = 1'b1;
        cycle("post_rst");
        proc_read(2'd3, "tx_stat_post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nic_fifo.md
Name: nic_fifo

Overview:
- Parametrised network interface controller between a processor's memory-mapped NIC port and one router port of the mesh NoC.
- Generalises the single-slot NIC to DEPTH-entry input and output FIFOs, with occupancy-reporting status registers.
- Keeps the processor register map and the polarity-gated, virtual-channel (VC) aware injection rule.

Parameters:
- PACKET_SIZE, 64, packet/data width in bits; vector bit 0 is the VC bit, bit PACKET_SIZE-1 is the LSB.
- DEPTH, 4, entries per FIFO; power of 2, at least 2.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width; must be at most PACKET_SIZE-3.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- addr  in  2  register select: 00 RX data, 01 RX status, 10 TX data, 11 TX status.
- d_in  in  [0:PACKET_SIZE-1]  processor write data.
- d_out  out  [0:PACKET_SIZE-1]  processor read data; combinational.
- nicEn  in  1  processor access strobe.
- nicEnWr  in  1  1 = write, 0 = read.
- net_si  in  1  router offers a packet to the NIC.
- net_ri  out  1  NIC can accept a packet (RX FIFO not full).
- net_di  in  [0:PACKET_SIZE-1]  packet from the router.
- net_so  out  1  NIC injects a packet.
- net_ro  in  1  router can accept a packet.
- net_do  out  [0:PACKET_SIZE-1]  head of the TX FIFO.
- net_polarity  in  1  router's current cycle polarity.

Behaviour:
- FIFO structure: each FIFO has a write pointer and a read pointer, each $clog2(DEPTH) bits and wrapping mod DEPTH, plus a CNT_W-bit count. full = (count==DEPTH); empty = (count==0).
- Reset (reset==0 at a clock edge): both FIFOs go to pointers 0 and count 0; sticky flags are cleared. Storage contents are not cleared.
  - While reset is held, outputs read as if the FIFOs are empty: net_ri=1, net_so=0, d_out=0.
  - A reset asserted mid-transfer discards all queued packets. No partial state survives.
- RX push: occurs when net_si && net_ri. Data is captured at the edge; count increments unless a pop happens in the same cycle.
  - net_ri = !rx_full. This is purely registered state, so a same-cycle pop does not raise net_ri.
- RX pop: a read at addr 00 (nicEn && !nicEnWr). Pops only if !rx_empty.
  - d_out = RX head combinationally; data is available in the same cycle as the read (zero latency).
  - Read at addr 00 while empty: d_out=0, no pop, pointers unchanged, rx_underflow set.
- Simultaneous RX push and pop: both pointers advance and count is unchanged. This is legal at any count, except that push is blocked when full.
- TX push: a write at addr 10 (nicEn && nicEnWr) while !tx_full. Writes to 00, 01 or 11 are ignored.
  - Write while full: d_in dropped, no state change, tx_overflow set.
  - Simultaneous TX push and pop follows the same rule as RX: push is blocked when full even if a pop occurs in that cycle.
- TX injection: net_do = TX head at all times; it is don't-care when empty.
  - net_so = !tx_empty && net_ro && (net_do[0] != net_polarity). That is, an even-VC packet (bit0=0) is sent when polarity=1, and an odd-VC packet (bit0=1) when polarity=0.
  - Pop on net_so; one packet per cycle maximum. Back-to-back injection is allowed while the condition holds.
  - A head blocked on polarity stalls the FIFO (no reordering).
- Status reads (addr 01 = RX, addr 11 = TX); all other d_out bits are 0:
  - d_out[PACKET_SIZE-1] = full.
  - d_out[PACKET_SIZE-2] = empty.
  - d_out[PACKET_SIZE-3] = sticky error (see Optional Feature).
  - d_out[0:CNT_W-1] = count, MSB-first.
- No access (nicEn=0): d_out=0.

Optional Feature:
- Macro NIC_FIFO_ERR_STATUS_EN.
- Defined:
  - rx_underflow and tx_overflow are sticky registers.
  - A status read of the matching direction returns the flag in d_out[PACKET_SIZE-3] and clears it at that edge (read-to-clear).
  - A set event in the same cycle as the clearing read wins: the flag stays 1.
- Undefined: no flag registers; d_out[PACKET_SIZE-3] always reads 0. Drop and no-pop behaviour is unchanged.

Test Plan:
- Reset: hold reset=0 for 2 cycles, release → net_ri=1, net_so=0; RX status read gives d_out[63]=0, d_out[62]=1, count 0.
- RX fill, DEPTH=4: net_si=1 with packets 0x11..0x44 → net_ri drops after the 4th push, status shows full=1 and count=4. Then four addr-00 reads return 0x11,0x22,0x33,0x44 in order, and net_ri=1 after the first pop.
- TX polarity: push 0x0...01 (bit0=0) then 0x8...00 (bit0=1) with net_ro=1 and polarity=0 → no injection. Switch polarity to 1 → first packet sent, net_so=1 for one cycle. Next cycle, polarity=0 → second packet sent.
- TX overflow: 5 writes to addr 10 with net_ro=0 → 5th dropped, count=4. With the macro defined, a TX status read shows bit61=1, and a second read shows 0.
- Simultaneous RX push and pop at count=2 over 8 cycles → count stays 2, data stays in order, pointers wrap past DEPTH correctly.
- Mid-operation reset with TX count=3 → after reset, TX empty=1 and net_so=0 even with polarity matching.
